// File: rtl/sa_w_channel_pkg.sv
// Shared AXI interconnect definitions: master ID width derivation and W-info packing.
// The W info word is {WDATA, WLAST}; the dispatcher W path packs it the same way.
package sa_w_channel_pkg;

    localparam int unsigned W_LAST_POS = 0;
    localparam int unsigned W_DATA_LSB = 1;

    function automatic int unsigned id_width(input int unsigned mst_amt);
        return (mst_amt > 1) ? $clog2(mst_amt) : 1;
    endfunction

    function automatic int unsigned w_info_width(input int unsigned data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/sa_w_grant_fifo.sv
// Grant-order FIFO of master IDs; head selects which dispatcher's W stream is forwarded.
module sa_w_grant_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_en, pop_en;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rptr_q];

    // Pushes while full and pops while empty are dropped.
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_en) wptr_q <= wptr_q + PTR_W'(1);
            if (pop_en)  rptr_q <= rptr_q + PTR_W'(1);
            unique case ({push_en, pop_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wptr_q] <= push_data_i;
    end

endmodule

// File: rtl/skid_buffer.sv
// Valid/ready pipeline stage; FULL=1 registers both directions with a 2-entry skid,
// FULL=0 is a single-entry stage with a combinational ready path.
module skid_buffer #(
    parameter int unsigned WIDTH = 8,
    parameter bit          FULL  = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             bwd_valid_i,
    input  logic [WIDTH-1:0] bwd_data_i,
    output logic             bwd_ready_o,
    output logic             fwd_valid_o,
    output logic [WIDTH-1:0] fwd_data_o,
    input  logic             fwd_ready_i
);

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_free, in_fire;

    assign out_free    = ~out_valid_q | fwd_ready_i;
    assign in_fire     = bwd_valid_i & bwd_ready_o;
    assign fwd_valid_o = out_valid_q;
    assign fwd_data_o  = out_data_q;

    if (FULL) begin : g_full
        logic             skid_valid_q;
        logic [WIDTH-1:0] skid_data_q;

        assign bwd_ready_o = ~skid_valid_q;

        // A held skid entry always drains before new input is taken.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                out_valid_q  <= 1'b0;
                out_data_q   <= '0;
                skid_valid_q <= 1'b0;
                skid_data_q  <= '0;
            end else if (out_free) begin
                out_valid_q  <= skid_valid_q | in_fire;
                if (skid_valid_q)  out_data_q <= skid_data_q;
                else if (in_fire)  out_data_q <= bwd_data_i;
                skid_valid_q <= 1'b0;
            end else if (in_fire) begin
                skid_valid_q <= 1'b1;
                skid_data_q  <= bwd_data_i;
            end
        end
    end else begin : g_half
        assign bwd_ready_o = out_free;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end else if (out_free) begin
                out_valid_q <= bwd_valid_i;
                if (bwd_valid_i) out_data_q <= bwd_data_i;
            end
        end
    end

endmodule

// File: rtl/sa_w_channel.sv
// Slave-side W-channel arbiter: forwards W beats from the dispatcher at the head of the
// grant-order FIFO to the slave through a full skid buffer; pops on the accepted WLAST.
module sa_w_channel
    import sa_w_channel_pkg::*;
#(
    parameter int unsigned MST_AMT         = 2,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MST_ID_W        = id_width(MST_AMT),
    parameter int unsigned OUTSTANDING_AMT = 4
) (
    input  logic                          ACLK_i,
    input  logic                          ARESETn_i,
    input  logic [DATA_WIDTH*MST_AMT-1:0] dsp_WDATA_i,
    input  logic [MST_AMT-1:0]            dsp_WLAST_i,
    input  logic [MST_AMT-1:0]            dsp_WVALID_i,
    output logic [MST_AMT-1:0]            dsp_WREADY_o,
    input  logic [MST_ID_W-1:0]           sa_AW_mst_id_i,
    input  logic                          sa_AW_grant_valid_i,
    output logic                          sa_AW_grant_ready_o,
    output logic [DATA_WIDTH-1:0]         s_WDATA_o,
    output logic                          s_WLAST_o,
    output logic                          s_WVALID_o,
    input  logic                          s_WREADY_i
);

    localparam int unsigned INFO_W = w_info_width(DATA_WIDTH);

    logic [MST_ID_W-1:0]   head_id;
    logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic                  sel_valid, sel_last, skid_ready;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [INFO_W-1:0]     skid_in, skid_out;

    // Readies are held low while reset is asserted, not only after the edge.
    assign sa_AW_grant_ready_o = ARESETn_i & ~fifo_full;
    assign fifo_push           = sa_AW_grant_valid_i & sa_AW_grant_ready_o;
    assign fifo_pop            = sel_valid & skid_ready & sel_last;

    always_comb begin
        sel_valid    = 1'b0;
        sel_last     = 1'b0;
        sel_data     = '0;
        dsp_WREADY_o = '0;
        for (int m = 0; m < MST_AMT; m++) begin
            if (!fifo_empty && head_id == MST_ID_W'(m)) begin
                sel_valid       = dsp_WVALID_i[m];
                sel_last        = dsp_WLAST_i[m];
                sel_data        = dsp_WDATA_i[DATA_WIDTH*m +: DATA_WIDTH];
                dsp_WREADY_o[m] = skid_ready & ARESETn_i;
            end
        end
    end

    assign skid_in    = {sel_data, sel_last};
    assign s_WDATA_o  = skid_out[W_DATA_LSB +: DATA_WIDTH];
    assign s_WLAST_o  = skid_out[W_LAST_POS];

    sa_w_grant_fifo #(
        .DEPTH (OUTSTANDING_AMT),
        .WIDTH (MST_ID_W)
    ) u_grant_fifo (
        .clk_i       (ACLK_i),
        .rst_ni      (ARESETn_i),
        .push_i      (fifo_push),
        .push_data_i (sa_AW_mst_id_i),
        .pop_i       (fifo_pop),
        .head_o      (head_id),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    skid_buffer #(
        .WIDTH (INFO_W),
        .FULL  (1'b1)
    ) u_skid (
        .clk_i       (ACLK_i),
        .rst_ni      (ARESETn_i),
        .bwd_valid_i (sel_valid),
        .bwd_data_i  (skid_in),
        .bwd_ready_o (skid_ready),
        .fwd_valid_o (s_WVALID_o),
        .fwd_data_o  (skid_out),
        .fwd_ready_i (s_WREADY_i)
    );

endmodule
